// File: rtl/cpu_phase_pkg.sv
// Shared types and defaults for the CPU phase scheduler.
// Holds the FSM state encoding, the parameter defaults and the phase-index width helper.
package cpu_phase_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_WAIT_MEM = 2'd2,
        S_ERR      = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_MEM_PHASE  = 2;
    localparam int DEF_MAX_WAIT   = 15;
    localparam int WAIT_CNT_W     = 8;

    // Width of the phase index; a single bit is still needed when there are two phases.
    function automatic int phase_idx_w(input int num_phases);
        return (num_phases <= 2) ? 1 : $clog2(num_phases);
    endfunction

endpackage

// File: rtl/cpu_phase_scheduler_wait_timer.sv
// Saturating wait counter for the memory-stall phase.
// timeout_o goes high in the cycle where the current wait cycle is the LIMIT-th one.
module phase_wait_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic         timeout_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/cpu_phase_scheduler.sv
// Sequences CPU instruction phases with registered one-hot enables, a memory-ready
// stall on one phase, a wait timeout, and run / halt / single-step control.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | between instructions, waiting for run_i or step_i
// S_RUN    | one phase enable high per cycle
// S_WAIT_MEM | memory phase issued, holding mem_req_o until ready
// S_ERR    | memory wait timed out; sticky until err_clr_i
module cpu_phase_scheduler
    import cpu_phase_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int MEM_PHASE  = DEF_MEM_PHASE,
    parameter int MAX_WAIT   = DEF_MAX_WAIT,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  halt_i,
    input  logic                  mem_ready_i,
    input  logic                  err_clr_i,
    output logic [NUM_PHASES-1:0] phase_en_o,
    output logic                  mem_req_o,
    output logic                  instr_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      instr_cnt_o
);

    localparam int IDX_W = phase_idx_w(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
    localparam logic [IDX_W-1:0] MEM_IDX  = IDX_W'(MEM_PHASE);

    if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
        $error("cpu_phase_scheduler: NUM_PHASES must be 2..8");
    end
    if (MEM_PHASE < 0 || MEM_PHASE >= NUM_PHASES) begin : g_bad_mem_phase
        $error("cpu_phase_scheduler: MEM_PHASE must be 0..NUM_PHASES-1");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("cpu_phase_scheduler: MAX_WAIT must be 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cpu_phase_scheduler: CNT_W must be at least 1");
    end

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  step_mode_q, step_mode_d;
    logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
    logic                  mem_req_q, mem_req_d;
    logic                  instr_done_q, instr_done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  retire;
    logic                  timeout;

    phase_wait_timer #(
        .W     (WAIT_CNT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q != S_WAIT_MEM),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (state_q == S_WAIT_MEM),
        .timeout_o  (timeout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i && !halt_i) begin
                    state_d     = S_RUN;
                    idx_d       = '0;
                    step_mode_d = 1'b0;
                end else if (step_i) begin
                    state_d     = S_RUN;
                    idx_d       = '0;
                    step_mode_d = 1'b1;
                end
            end
            S_RUN: begin
                if ((idx_q == MEM_IDX) && !mem_ready_i) begin
                    state_d = S_WAIT_MEM;
                end else if (idx_q == LAST_IDX) begin
                    retire = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT_MEM: begin
                // Ready beats a coincident timeout.
                if (mem_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        retire = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (err_clr_i) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Instruction boundary: run/halt are only looked at here.
        if (retire) begin
            idx_d   = '0;
            state_d = (run_i && !halt_i && !step_mode_q) ? S_RUN : S_IDLE;
        end

        phase_en_d   = (state_d == S_RUN) ? (NUM_PHASES'(1) << idx_d) : '0;
        mem_req_d    = ((state_d == S_RUN) && (idx_d == MEM_IDX)) || (state_d == S_WAIT_MEM);
        instr_done_d = (state_d == S_RUN) && (idx_d == LAST_IDX);
        busy_d       = (state_d == S_RUN) || (state_d == S_WAIT_MEM);
        err_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            step_mode_q  <= 1'b0;
            phase_en_q   <= '0;
            mem_req_q    <= 1'b0;
            instr_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            step_mode_q  <= step_mode_d;
            phase_en_q   <= phase_en_d;
            mem_req_q    <= mem_req_d;
            instr_done_q <= instr_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            if (retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign phase_en_o   = phase_en_q;
    assign mem_req_o    = mem_req_q;
    assign instr_done_o = instr_done_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign instr_cnt_o  = cnt_q;

endmodule
